// File: rtl/vga_frame_reader_if.sv
// rtl/vga_frame_reader_if.sv - framebuffer RAM read port between the display reader and the RAM
interface vga_frame_reader_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] oRAM_Address;
    logic              oRAM_ReadEnable;
    logic [2:0]        iRAM_Data;

    modport master (
        output oRAM_Address,
        output oRAM_ReadEnable,
        input  iRAM_Data
    );

    modport slave (
        input  oRAM_Address,
        input  oRAM_ReadEnable,
        output iRAM_Data
    );
endinterface

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - VGA timing generator that scans a top-left framebuffer window
module vga_frame_reader #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int FB_W   = 256,
    parameter int FB_H   = 256,
    parameter int ADDR_W = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    vga_frame_reader_if.master  ram,
    output logic                oVGA_Red,
    output logic                oVGA_Green,
    output logic                oVGA_Blue,
    output logic                oVGA_HSync,
    output logic                oVGA_VSync,
    output logic                oFrameStart
);
    localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FB_SHIFT = $clog2(FB_W);

    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_C = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);
    localparam logic [9:0] FB_W_C  = 10'(FB_W);
    localparam logic [9:0] FB_H_C  = 10'(FB_H);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic              toggle;
    logic              tick;
    logic [9:0]        hcnt;
    logic [9:0]        vcnt;
    logic              inwin;
    logic              visible;
    logic              hs_now;
    logic              vs_now;
    logic [ADDR_W-1:0] addr_next;

    logic [ADDR_W-1:0] addr_q;
    logic              re_q;
    logic              win_d;
    logic              hs_d;
    logic              vs_d;
    logic [2:0]        pix_q;
    logic [2:0]        rgb_q;
    logic              hsync_q;
    logic              vsync_q;
    logic              frame_q;

    // toggle resets low so the very first edge after release is a pixel tick
    assign tick = ~toggle;

    always_comb begin
        inwin     = (hcnt < FB_W_C) && (vcnt < FB_H_C);
        visible   = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
        hs_now    = ~((hcnt >= HS_BEG) && (hcnt <= HS_END));
        vs_now    = ~((vcnt >= VS_BEG) && (vcnt <= VS_END));
        addr_next = (ADDR_W'(vcnt) << FB_SHIFT) + ADDR_W'(hcnt);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            toggle  <= 1'b0;
            hcnt    <= '0;
            vcnt    <= '0;
            addr_q  <= '0;
            re_q    <= 1'b0;
            win_d   <= 1'b0;
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
            pix_q   <= 3'b000;
            rgb_q   <= 3'b000;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            toggle  <= ~toggle;
            re_q    <= 1'b0;
            frame_q <= 1'b0;
            if (tick) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
                frame_q <= (hcnt == 10'd0) && (vcnt == 10'd0);
                if (inwin) begin
                    addr_q <= addr_next;
                    re_q   <= 1'b1;
                end
                // second stage: pixel and syncs of the previous tick leave together
                win_d   <= inwin && visible;
                hs_d    <= hs_now;
                vs_d    <= vs_now;
                rgb_q   <= win_d ? pix_q : 3'b000;
                hsync_q <= hs_d;
                vsync_q <= vs_d;
            end else begin
                pix_q <= ram.iRAM_Data;
            end
        end
    end

    assign ram.oRAM_Address    = addr_q;
    assign ram.oRAM_ReadEnable = re_q;
    assign oVGA_Red            = rgb_q[2];
    assign oVGA_Green          = rgb_q[1];
    assign oVGA_Blue           = rgb_q[0];
    assign oVGA_HSync          = hsync_q;
    assign oVGA_VSync          = vsync_q;
    assign oFrameStart         = frame_q;
endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Display-side reader of the video framebuffer that the CPU fills with `VGA` pixel writes.
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock, scans the framebuffer RAM read port and drives 1-bit-per-channel RGB plus sync.
- The framebuffer window sits at the top-left of the screen. Visible pixels outside the window are driven black.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- FB_W, 256, framebuffer width in pixels (power of two)
- FB_H, 256, framebuffer height in lines
- ADDR_W, 16, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H

Ports:
- Clock  in  1  50 MHz system clock
- Reset  in  1  asynchronous, active-low reset
- oRAM_Address  out  ADDR_W  framebuffer read address = row*FB_W + col
- oRAM_ReadEnable  out  1  high on the cycle an in-window address is issued
- iRAM_Data  in  3  {R,G,B} returned one Clock after the address (synchronous RAM)
- oVGA_Red  out  1  red
- oVGA_Green  out  1  green
- oVGA_Blue  out  1  blue
- oVGA_HSync  out  1  horizontal sync, active low
- oVGA_VSync  out  1  vertical sync, active low
- oFrameStart  out  1  one-Clock pulse at the start of each frame (hcnt=0, vcnt=0 pixel tick)

Behaviour:
- Reset (async, Reset=0):
  - PixelTick toggle=0, hcnt=0, vcnt=0.
  - oRAM_Address=0, oRAM_ReadEnable=0, RGB=000, oVGA_HSync=1, oVGA_VSync=1, oFrameStart=0.
  - Reset asserted mid-line or mid-frame forces these values immediately. The first tick after release is hcnt=0, vcnt=0.
- PixelTick:
  - Toggles every Clock; it is high on the first Clock edge after reset release and on every second edge after that (25 MHz).
  - Every other register updates only on PixelTick=1 cycles, except the RAM data capture described below.
- Counters:
  - hcnt counts 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800. At H_TOT-1 it wraps to 0 and vcnt increments.
  - vcnt counts 0..V_TOT-1 (525). vcnt wraps to 0 when hcnt and vcnt both wrap on the same tick.
- Window:
  - inwin = (hcnt<FB_W) && (vcnt<FB_H).
  - Visible region: hcnt<H_VIS && vcnt<V_VIS.
- Pipeline stage 0 (tick at counters h,v):
  - oRAM_Address <= v*FB_W+h; this is a shift because FB_W is a power of two.
  - oRAM_ReadEnable=1 for exactly one Clock when inwin.
  - Out of window: address held, ReadEnable=0.
- RAM data capture: on the Clock following stage 0 (the PixelTick=0 cycle), iRAM_Data is captured into pix_q.
- Stage 1 (next tick): RGB outputs are driven as follows.
  - {oVGA_Red,oVGA_Green,oVGA_Blue} <= pix_q if the delayed inwin is set.
  - 000 if the delayed position is visible but outside the window, or in blanking.
- Syncs:
  - oVGA_HSync=0 for hcnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. [656,751].
  - oVGA_VSync=0 for vcnt in [490,491].
  - Both are delayed through the same one-tick pipeline as RGB, so pixel, sync and blank stay aligned.
- Total latency: counter position to RGB output is 1 pixel tick (2 Clocks). Syncs carry an identical delay.
- oFrameStart is high for one Clock on the tick where the counters equal (0,0). It is not delayed.
- RGB is never non-zero during blanking, whatever iRAM_Data holds.
- Widths: address arithmetic is ADDR_W bits and has no overflow within the window. Counters are 10 bits.

Test Plan:
- Reset released at t0 -> oFrameStart pulses on Clock 1; oVGA_HSync falls 656 ticks (1312 Clocks) plus the 1-tick latency after frame start; HSync period is 1600 Clocks.
- Run 2 frames -> VSync low for exactly 2 lines (3200 Clocks); frame period 800*525*2 = 840000 Clocks; oFrameStart pulses once per frame.
- RAM model returns data = address[2:0] -> output pixel at (h=5, v=3) shows RGB=101; addresses issued for row 1 start at 256; no ReadEnable at h>=256 or v>=256.
- RAM model returns 111 constantly -> RGB=000 for h in [256,639] and in all blanking intervals; RGB=111 inside the window.
- Checkerboard RAM (32-pixel squares, white at (0,0)) -> pixel (31,0)=111, (32,0)=000, (0,32)=000, (32,32)=111.
- Assert Reset mid-frame at (h=300, v=100) -> all outputs return to reset values within the same cycle; after release, timing restarts at (0,0) with an oFrameStart pulse.
